// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit: computes bias + sum(in_i * w_i) in signed fixed point, one MAC per cycle.
// Operands are snapshotted on an accepted start. The 67-bit accumulator holds Q34.32 at the
// default parameters. The result is saturated back to DATA_WIDTH.
// Optional feature: define NEURON_RELU_EN to clamp negative results to zero in the OUT state.
`timescale 1ns/1ps

module neuron_mac_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [2:0]            wAddress,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  wWrite,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + 3;
  localparam int unsigned TAPS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                state_q, state_next;
  logic                  load_c, mac_c, fin_c;

  logic [DATA_WIDTH-1:0] coef_w  [TAPS];
  logic [DATA_WIDTH-1:0] bias_q;
  logic [DATA_WIDTH-1:0] snap_in [TAPS];
  logic [DATA_WIDTH-1:0] snap_w  [TAPS];
  logic [DATA_WIDTH-1:0] in_vec  [TAPS];

  logic [ACC_W-1:0]      acc_q;
  logic [1:0]            idx_q;

  logic [PROD_W-1:0]     op_a, op_b, prod;
  logic [ACC_W-1:0]      prod_ext, bias_ext, shifted;
  logic                  pos_ovf, neg_ovf;
  logic [DATA_WIDTH-1:0] sat_val, res_val;

  assign in_vec[0] = in0;
  assign in_vec[1] = in1;
  assign in_vec[2] = in2;
  assign in_vec[3] = in3;

  // Coefficient registers, writable every cycle; addresses 5-7 are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) coef_w[i] <= '0;
      bias_q <= '0;
    end else if (wWrite) begin
      if (!wAddress[2]) coef_w[wAddress[1:0]] <= wData;
      else if (wAddress[1:0] == 2'd0) bias_q <= wData;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_next;
  end

  // Next-state and per-state enables; start is only honoured in IDLE.
  always_comb begin
    state_next = state_q;
    load_c     = 1'b0;
    mac_c      = 1'b0;
    fin_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_c = 1'b1;
        if (idx_q == 2'd3) state_next = ST_OUT;
      end
      ST_OUT: begin
        fin_c      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Signed product, bias alignment, arithmetic shift and saturation.
  always_comb begin
    op_a     = {{DATA_WIDTH{snap_in[idx_q][DATA_WIDTH-1]}}, snap_in[idx_q]};
    op_b     = {{DATA_WIDTH{snap_w[idx_q][DATA_WIDTH-1]}}, snap_w[idx_q]};
    prod     = op_a * op_b;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_WIDTH-FRAC_BITS){bias_q[DATA_WIDTH-1]}}, bias_q, {FRAC_BITS{1'b0}}};
    shifted  = {{FRAC_BITS{acc_q[ACC_W-1]}}, acc_q[ACC_W-1:FRAC_BITS]};
    pos_ovf  = ~shifted[ACC_W-1] & (|shifted[ACC_W-2:DATA_WIDTH-1]);
    neg_ovf  = shifted[ACC_W-1] & ~(&shifted[ACC_W-2:DATA_WIDTH-1]);
    if (pos_ovf)      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (neg_ovf) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else              sat_val = shifted[DATA_WIDTH-1:0];
`ifdef NEURON_RELU_EN
    res_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  // Snapshot, accumulate and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        snap_in[i] <= '0;
        snap_w[i]  <= '0;
      end
      acc_q  <= '0;
      idx_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= fin_c;
      if (load_c) begin
        for (int i = 0; i < int'(TAPS); i++) begin
          snap_in[i] <= in_vec[i];
          snap_w[i]  <= coef_w[i];
        end
        acc_q <= bias_ext;
        idx_q <= '0;
      end
      if (mac_c) begin
        acc_q <= acc_q + prod_ext;
        idx_q <= idx_q + 2'd1;
      end
      if (fin_c) result <= res_val;
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Testbench for neuron_mac_unit: table of vectors with a result scoreboard plus corner sequences.
`timescale 1ns/1ps

module tb_neuron_mac_unit;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [3:0][31:0] in_v;
    logic [3:0][31:0] w_v;
    logic [31:0]      bias;
    logic [31:0]      exp_r;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] in_d [4];
  logic [2:0]  wAddress;
  logic [31:0] wData;
  logic        wWrite;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks;
  int          passes;
  int          done_count;
  logic [31:0] sb [$];

  neuron_mac_unit dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in_d[0]),
    .in1      (in_d[1]),
    .in2      (in_d[2]),
    .in3      (in_d[3]),
    .wAddress (wAddress),
    .wData    (wData),
    .wWrite   (wWrite),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got result %h with empty scoreboard", result);
      end else begin
        check("result", result, sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] lin(input logic [31:0] v);
    return (RELU && v[31]) ? 32'h0 : v;
  endfunction

  function automatic vec_t mk(input logic [31:0] i0, i1, i2, i3, w0, w1, w2, w3, b, e);
    vec_t v;
    v.in_v  = {i3, i2, i1, i0};
    v.w_v   = {w3, w2, w1, w0};
    v.bias  = b;
    v.exp_r = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [31:0] data);
    wAddress = addr;
    wData    = data;
    wWrite   = 1'b1;
    tick();
    wWrite   = 1'b0;
  endtask

  task automatic set_in(input logic [31:0] a, b, c, d);
    in_d[0] = a; in_d[1] = b; in_d[2] = c; in_d[3] = d;
  endtask

  // Start one evaluation, scramble inputs after the snapshot edge and return in the done cycle.
  task automatic run_eval(input string name, input logic [31:0] exp);
    int cyc;
    start = 1'b1;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) in_d[i] = $urandom;
    check({name, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
    check({name, "_latency"}, 32'(cyc), 32'd5);
  endtask

  vec_t vecs [14];
  int   dc0;

  initial begin
    checks = 0; passes = 0; done_count = 0;
    reset = 1'b1; wAddress = '0; wData = '0; wWrite = 1'b0; start = 1'b0;
    set_in(0, 0, 0, 0);
    tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    tick();

    vecs[0]  = mk(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
                  32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 32'h0, 32'h00020000);
    vecs[1]  = mk(32'h00010000, 0, 0, 0, 32'hFFFF0000, 0, 0, 0, 32'h0, lin(32'hFFFF0000));
    vecs[2]  = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[3]  = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, lin(32'h80000000));
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00030000, 32'h00030000);
    vecs[5]  = mk(32'h00020000, 32'hFFFF0000, 0, 0, 32'h00018000, 32'h00008000, 0, 0,
                  32'h00010000, 32'h00038000);
    vecs[6]  = mk(32'h1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 32'h0, lin(32'hFFFFFFFF));
    vecs[7]  = mk(32'h1, 0, 0, 0, 32'h1, 0, 0, 0, 32'h0, 32'h0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h80000000, lin(32'h80000000));
    vecs[10] = mk(32'h1, 0, 0, 0, 32'h00010000, 0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[11] = mk(32'h1, 0, 0, 0, 32'hFFFF0000, 0, 0, 0, 32'h80000000, lin(32'h80000000));
    vecs[12] = mk(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000,
                  32'h00010000, 0, 0, 32'h00020000, 32'h0, 32'h00090000);
    vecs[13] = mk(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
                  32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h0, lin(32'hFFF60000));

    for (int v = 0; v < 14; v++) begin
      for (int k = 0; k < 4; k++) write_coef(3'(k), vecs[v].w_v[k]);
      write_coef(3'd4, vecs[v].bias);
      set_in(vecs[v].in_v[0], vecs[v].in_v[1], vecs[v].in_v[2], vecs[v].in_v[3]);
      run_eval($sformatf("vec%0d", v), vecs[v].exp_r);
    end

    // Mid-run coefficient write goes to registers only; unused addresses are inert.
    for (int k = 0; k < 4; k++) write_coef(3'(k), 32'h0);
    write_coef(3'd4, 32'h00030000);
    write_coef(3'd5, 32'h12345678);
    write_coef(3'd6, 32'h7FFFFFFF);
    write_coef(3'd7, 32'h80000000);
    set_in(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    start = 1'b1;
    sb.push_back(32'h00030000);
    tick();
    start = 1'b0;
    tick();
    write_coef(3'd0, 32'h00010000);
    for (int i = 0; i < 10; i++) tick();
    check("t4_held", result, 32'h00030000);
    set_in(32'h00010000, 0, 0, 0);
    run_eval("t4_second", 32'h00040000);

    // Start held through MAC cycles 1-3 yields a single evaluation.
    tick(); tick();
    dc0 = done_count;
    set_in(32'h00010000, 0, 0, 0);
    start = 1'b1;
    sb.push_back(32'h00040000);
    tick(); tick(); tick(); tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("t5_single_done", 32'(done_count - dc0), 32'd1);

    // Back-to-back: start in the done cycle is accepted.
    dc0 = done_count;
    set_in(32'h00010000, 0, 0, 0);
    run_eval("t5_first", 32'h00040000);
    set_in(32'h00010000, 0, 0, 0);
    run_eval("t5_b2b", 32'h00040000);
    tick();
    check("t5_b2b_count", 32'(done_count - dc0), 32'd2);

    // Reset on the second MAC edge aborts the run and clears coefficients.
    write_coef(3'd4, 32'h00010000);
    set_in(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    dc0 = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_result", result, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("t6_no_done", 32'(done_count - dc0), 32'd0);
    set_in(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    run_eval("t6_cleared", 32'h0);

    tick(); tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
